// File: rtl/lot_occupancy_counter.sv
// Parking-lot occupancy tracker: live count, peak, admitted total, error pulses
// and a two-digit seven-segment decode of the current count.
module lot_occupancy_counter #(
  parameter int unsigned CAPACITY = 25,
  parameter int unsigned CW       = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enter,
  input  logic          exit,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic [CW-1:0] peak,
  output logic [15:0]   total,
  output logic          full,
  output logic          empty,
  output logic          overflow_err,
  output logic          underflow_err,
  output logic [6:0]    hex_tens,
  output logic [6:0]    hex_ones
);

  localparam int unsigned TW = 16;
  localparam logic [CW-1:0] CAP = CW'(CAPACITY);

  logic [CW-1:0] count_nxt;
  logic [CW-1:0] peak_nxt;
  logic [TW-1:0] total_nxt;
  logic          ovf_nxt;
  logic          unf_nxt;
  logic [3:0]    tens_c;
  logic [3:0]    ones_c;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count         <= '0;
      peak          <= '0;
      total         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      count         <= count_nxt;
      peak          <= peak_nxt;
      total         <= total_nxt;
      overflow_err  <= ovf_nxt;
      underflow_err <= unf_nxt;
    end
  end

  // Priority: clear, simultaneous enter/exit, enter, exit, hold.
  always_comb begin
    count_nxt = count;
    total_nxt = total;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    if (clear) begin
      count_nxt = '0;
      total_nxt = '0;
    end else if (enter && exit) begin
      total_nxt = total + TW'(1);
    end else if (enter) begin
      if (count == CAP) begin
        ovf_nxt = 1'b1;
      end else begin
        count_nxt = count + CW'(1);
        total_nxt = total + TW'(1);
      end
    end else if (exit) begin
      if (count == '0) begin
        unf_nxt = 1'b1;
      end else begin
        count_nxt = count - CW'(1);
      end
    end
  end

  always_comb begin
    peak_nxt = peak;
    if (clear) begin
      peak_nxt = '0;
    end else if (count_nxt > peak) begin
      peak_nxt = count_nxt;
    end
  end

  // Display and status flags decode the registered count only.
  always_comb begin
    tens_c   = 4'(count / CW'(10));
    ones_c   = 4'(count % CW'(10));
    hex_tens = seg7(tens_c);
    hex_ones = seg7(ones_c);
    full     = (count == CAP);
    empty    = (count == '0);
  end

endmodule

// File: tb/tb_lot_occupancy_counter.sv
// Bench for lot_occupancy_counter: vector table, directed corner sequences and
// randomized traffic against an arithmetic occupancy model.
module tb_lot_occupancy_counter;

  localparam int CAP = 25;

  logic       clk;
  logic       reset;
  logic       enter;
  logic       exit;
  logic       clear;
  logic [6:0] count;
  logic [6:0] peak;
  logic [15:0] total;
  logic       full;
  logic       empty;
  logic       overflow_err;
  logic       underflow_err;
  logic [6:0] hex_tens;
  logic [6:0] hex_ones;

  lot_occupancy_counter #(.CAPACITY(CAP), .CW(7)) dut (
    .clk           (clk),
    .reset         (reset),
    .enter         (enter),
    .exit          (exit),
    .clear         (clear),
    .count         (count),
    .peak          (peak),
    .total         (total),
    .full          (full),
    .empty         (empty),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err),
    .hex_tens      (hex_tens),
    .hex_ones      (hex_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_count;
  int m_peak;
  int m_total;
  int m_ovf;
  int m_unf;

  logic [6:0] seg_tbl [10];

  typedef struct {
    logic en;
    logic ex;
    logic cl;
    int   cnt;
    int   pk;
    int   tot;
    int   ovf;
    int   unf;
  } vec_t;

  vec_t vecs [9];

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_peak = 0; m_total = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step(input logic e, input logic x, input logic c);
    m_ovf = 0;
    m_unf = 0;
    if (c) begin
      m_count = 0; m_peak = 0; m_total = 0;
    end else if (e && x) begin
      m_total = (m_total + 1) % 65536;
    end else if (e) begin
      if (m_count < CAP) begin
        m_count++;
        m_total = (m_total + 1) % 65536;
      end else m_ovf = 1;
    end else if (x) begin
      if (m_count > 0) m_count--;
      else m_unf = 1;
    end
    if (m_count > m_peak) m_peak = m_count;
  endtask

  task automatic check_vs(input string tag, input int c, input int p, input int t,
                          input int o, input int u);
    cmp({tag, ".count"}, int'(count), c);
    cmp({tag, ".peak"}, int'(peak), p);
    cmp({tag, ".total"}, int'(total), t);
    cmp({tag, ".overflow_err"}, int'(overflow_err), o);
    cmp({tag, ".underflow_err"}, int'(underflow_err), u);
    cmp({tag, ".full"}, int'(full), int'(c == CAP));
    cmp({tag, ".empty"}, int'(empty), int'(c == 0));
    cmp({tag, ".hex_tens"}, int'(hex_tens), int'(seg_tbl[c / 10]));
    cmp({tag, ".hex_ones"}, int'(hex_ones), int'(seg_tbl[c % 10]));
  endtask

  task automatic check_model(input string tag);
    check_vs(tag, m_count, m_peak, m_total, m_ovf, m_unf);
  endtask

  // One clock with the given inputs; outputs settle and are sampled 1ns later.
  task automatic cycle(input logic e, input logic x, input logic c);
    enter = e; exit = x; clear = c;
    @(posedge clk);
    model_step(e, x, c);
    #1;
    enter = 1'b0; exit = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001; seg_tbl[2] = 7'b0100100;
    seg_tbl[3] = 7'b0110000; seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
    seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000; seg_tbl[8] = 7'b0000000;
    seg_tbl[9] = 7'b0010000;

    //            en    ex    cl    cnt pk tot ovf unf
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1, 1, 1, 0, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 2, 2, 2, 0, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 3, 3, 3, 0, 0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 2, 3, 3, 0, 0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 2, 3, 4, 0, 0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 0, 0, 1, 0, 0};

    enter = 1'b0; exit = 1'b0; clear = 1'b0;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_vs("reset", 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Table-driven vectors, starting from reset
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].en, vecs[i].ex, vecs[i].cl);
      check_vs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].pk, vecs[i].tot,
               vecs[i].ovf, vecs[i].unf);
    end

    // Fill to capacity, then one rejected entry, then the pulse clears
    do_reset();
    for (int i = 0; i < CAP; i++) cycle(1'b1, 1'b0, 1'b0);
    check_vs("fill25", 25, 25, 25, 0, 0);
    cycle(1'b1, 1'b0, 1'b0);
    check_vs("over", 25, 25, 25, 1, 0);
    cycle(1'b0, 1'b0, 1'b0);
    check_vs("over_drop", 25, 25, 25, 0, 0);

    // Simultaneous enter/exit at capacity, then drain five
    cycle(1'b1, 1'b1, 1'b0);
    check_vs("both_at_cap", 25, 25, 26, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0);
    check_vs("drain5", 20, 25, 26, 0, 0);

    // Lone exit from empty
    do_reset();
    cycle(1'b0, 1'b1, 1'b0);
    check_vs("under", 0, 0, 0, 0, 1);
    cycle(1'b0, 1'b0, 1'b0);
    check_vs("under_drop", 0, 0, 0, 0, 0);

    // Asynchronous reset between edges at count 10
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
    check_vs("at10", 10, 10, 10, 0, 0);
    #2;
    enter = 1'b1;
    reset = 1'b0;
    #1;
    check_vs("async_reset", 0, 0, 0, 0, 0);
    enter = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    check_vs("post_reset", 1, 1, 1, 0, 0);

    // Clear wins over enter at count 7
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    check_vs("clear_enter", 0, 0, 0, 0, 0);

    // Randomized traffic; entry bias drifts so both bounds get exercised
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int bias;
      logic e, x, c;
      bias = ((i / 300) % 2 == 0) ? 70 : 30;
      e = ($urandom_range(99) < bias);
      x = ($urandom_range(99) < (100 - bias));
      c = ($urandom_range(199) == 0);
      cycle(e, x, c);
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lot_occupancy_counter.md
LOT_OCCUPANCY_COUNTER -- requirements
Module: lot_occupancy_counter

Interface
REQ-001 Parameter CAPACITY, default 25, maximum cars in lot (legal range 1..99).
REQ-002 Parameter CW, default 7, width of count and peak (must hold 99).
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; all state cleared while low.
REQ-005 enter  input  1  one-cycle pulse, car entered (from upstream car detector).
REQ-006 exit  input  1  one-cycle pulse, car exited (from upstream car detector).
REQ-007 clear  input  1  synchronous clear of count, peak, total and error outputs.
REQ-008 count  output  CW  current occupancy, registered.
REQ-009 peak  output  CW  highest occupancy since last reset/clear, registered.
REQ-010 total  output  16  cars admitted since last reset/clear, registered, wraps.
REQ-011 full  output  1  high when count == CAPACITY.
REQ-012 empty  output  1  high when count == 0.
REQ-013 overflow_err  output  1  one-cycle pulse, entry rejected at capacity.
REQ-014 underflow_err  output  1  one-cycle pulse, exit rejected at zero.
REQ-015 hex_tens, hex_ones  output  7 each  active-low seven-segment, order {g,f,e,d,c,b,a}, decimal digits of count.

Function
REQ-016 Inputs sampled on rising clk edge k; count, peak, total, error pulses update at edge k (visible after k), latency one cycle.
REQ-017 Priority per edge: clear > (enter & exit) > enter > exit > hold.
REQ-018 clear=1: count, peak, total <- 0; overflow_err, underflow_err <- 0; enter/exit that cycle ignored.
REQ-019 enter & exit same cycle: count holds, total +1, no error pulse, at any count including 0 and CAPACITY.
REQ-020 enter only, count < CAPACITY: count +1, total +1.
REQ-021 enter only, count == CAPACITY: count holds, total holds, overflow_err = 1 for exactly one cycle.
REQ-022 exit only, count > 0: count -1.
REQ-023 exit only, count == 0: count holds, underflow_err = 1 for exactly one cycle.
REQ-024 Error outputs are registered and deassert the cycle after their event unless the event repeats.
REQ-025 peak <- max(peak, next count) on the same edge as count update; peak never decreases except on clear/reset.
REQ-026 total is 16-bit unsigned; 65535 + 1 wraps to 0 with no flag.
REQ-027 count never exceeds CAPACITY and never goes below 0 under any input sequence.
REQ-028 full, empty, hex_tens, hex_ones are combinational decodes of registered count only.
REQ-029 hex encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; tens digit shows 0 when count < 10.

Reset
REQ-030 reset low asserts immediately, without waiting for clk: count=0, peak=0, total=0, overflow_err=0, underflow_err=0, hence empty=1, full=0, hex_tens=hex_ones=1000000.
REQ-031 reset low mid-operation discards in-flight enter/exit; first edge after reset releases samples inputs normally.
REQ-032 Deassertion of reset is assumed synchronised externally; the block adds no reset synchroniser.

Verification
REQ-033 reset, then 3 enter pulses -> count=3, peak=3, total=3, empty=0, hex_tens=1000000, hex_ones=0110000.
REQ-034 25 enter pulses then 1 more -> count=25, full=1, total=25, overflow_err high exactly one cycle, hex_tens=0100100, hex_ones=0010010.
REQ-035 from reset, one exit pulse -> count=0, empty=1, underflow_err high exactly one cycle, total=0.
REQ-036 count=25, enter=exit=1 one cycle -> count=25, total=26, no error pulse; then 5 exits -> count=20, peak=25.
REQ-037 count=10, reset driven low between clk edges -> count=0, peak=0, total=0 before next edge.
REQ-038 count=7, clear=1 with enter=1 same cycle -> count=0, peak=0, total=0, no error pulse.
